// File: rtl/puck_pkg.sv
// Shared puck physics constants, FSM state encoding and velocity helpers.
package puck_pkg;

  localparam int unsigned RADIUS    = 10;
  localparam int unsigned SCREEN_W  = 1024;
  localparam int unsigned SCREEN_H  = 768;
  localparam int unsigned GOAL_TOP  = 284;
  localparam int unsigned GOAL_BOT  = 484;
  localparam int unsigned HIT_SPEED = 6;
  localparam int unsigned MAX_SPEED = 12;

  typedef logic signed [12:0] coord_t;
  typedef logic [1:0] state_t;

  localparam state_t StWait = 2'd0;
  localparam state_t StHit  = 2'd1;
  localparam state_t StWall = 2'd2;
  localparam state_t StMove = 2'd3;

  localparam coord_t Zero     = 13'sd0;
  localparam coord_t RadS     = coord_t'(RADIUS);
  localparam coord_t XEdge    = coord_t'(SCREEN_W - 1);
  localparam coord_t YEdge    = coord_t'(SCREEN_H - 1);
  localparam coord_t XMax     = coord_t'(SCREEN_W - 1 - RADIUS);
  localparam coord_t YMax     = coord_t'(SCREEN_H - 1 - RADIUS);
  localparam coord_t GoalTopS = coord_t'(GOAL_TOP);
  localparam coord_t GoalBotS = coord_t'(GOAL_BOT);
  localparam coord_t HitS     = coord_t'(HIT_SPEED);
  localparam coord_t MaxS     = coord_t'(MAX_SPEED);
  localparam logic [11:0] XMid = 12'(SCREEN_W / 2);
  localparam logic [11:0] YMid = 12'(SCREEN_H / 2);

  function automatic coord_t sat(input coord_t v);
    if (v > MaxS) return MaxS;
    else if (v < -MaxS) return -MaxS;
    else return v;
  endfunction

  function automatic coord_t hit_vel(input logic neg);
    return neg ? -HitS : HitS;
  endfunction

endpackage

// File: rtl/circle_hit.sv
// Combinational circle-circle overlap test: a hits b when centre distance^2 <= (ra+rb)^2.
module circle_hit (
  input  logic [11:0] a_x,
  input  logic [11:0] a_y,
  input  logic [7:0]  a_r,
  input  logic [11:0] b_x,
  input  logic [11:0] b_y,
  input  logic [7:0]  b_r,
  output logic        hit,
  output logic        neg_x,
  output logic        neg_y,
  output logic        zero_y
);

  logic signed [12:0] dx, dy;
  logic [11:0] adx, ady;
  logic [25:0] d2;
  logic [8:0]  rsum;
  logic [17:0] thr;

  always_comb begin
    dx   = $signed({1'b0, a_x}) - $signed({1'b0, b_x});
    dy   = $signed({1'b0, a_y}) - $signed({1'b0, b_y});
    adx  = 12'(dx[12] ? -dx : dx);
    ady  = 12'(dy[12] ? -dy : dy);
    d2   = 26'(adx) * 26'(adx) + 26'(ady) * 26'(ady);
    rsum = 9'(a_r) + 9'(b_r);
    thr  = 18'(rsum) * 18'(rsum);
    hit    = (d2 <= 26'(thr));
    neg_x  = dx[12];
    neg_y  = dy[12];
    zero_y = (dy == 13'sd0);
  end

endmodule

// File: rtl/puck_ctl.sv
// Frame-rate puck physics: per vsync tick runs HIT -> WALL -> MOVE and updates position/score.
// Optional friction decay enabled by defining PUCK_FRICTION_EN.
module puck_ctl
  import puck_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic [11:0] player_xpos_in,
  input  logic [11:0] player_ypos_in,
  input  logic [7:0]  radius_player,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic [7:0]  radius_puck,
  output logic        goal_left,
  output logic        goal_right,
  output logic        busy
);

  state_t      state_q, state_d;
  logic        vsync_q, tick;
  logic [11:0] x_q, x_d, y_q, y_d;
  coord_t      vx_q, vx_d, vy_q, vy_d;
  logic [11:0] px_q, px_d, py_q, py_d;
  logic [7:0]  pr_q, pr_d;
  logic        goal_l_q, goal_l_d, goal_r_q, goal_r_d;
  logic        hit, neg_x, neg_y, zero_y;
  coord_t      xs, ys, nx, ny;
  logic [11:0] nx_c, ny_c;
  logic        band_cur, band_new;

`ifdef PUCK_FRICTION_EN
  localparam int unsigned FRICTION_PERIOD = 8;
  localparam int unsigned FcntW = $clog2(FRICTION_PERIOD);
  logic [FcntW-1:0] fcnt_q, fcnt_d;
`endif

  circle_hit u_hit (
    .a_x   (x_q),
    .a_y   (y_q),
    .a_r   (8'(RADIUS)),
    .b_x   (px_q),
    .b_y   (py_q),
    .b_r   (pr_q),
    .hit   (hit),
    .neg_x (neg_x),
    .neg_y (neg_y),
    .zero_y(zero_y)
  );

  assign tick = vsync_in & ~vsync_q;

  always_comb begin
    xs       = $signed({1'b0, x_q});
    ys       = $signed({1'b0, y_q});
    nx       = xs + vx_q;
    ny       = ys + vy_q;
    band_cur = (ys >= GoalTopS) && (ys <= GoalBotS);
    band_new = (ny >= GoalTopS) && (ny <= GoalBotS);
    ny_c     = (ny < RadS) ? 12'(RadS) : (ny > YMax) ? 12'(YMax) : 12'(ny);
    // Inside the goal band x is left unclamped so the puck can reach the goal line.
    if (band_new) nx_c = 12'(nx);
    else          nx_c = (nx < RadS) ? 12'(RadS) : (nx > XMax) ? 12'(XMax) : 12'(nx);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    px_d     = px_q;
    py_d     = py_q;
    pr_d     = pr_q;
    goal_l_d = 1'b0;
    goal_r_d = 1'b0;
`ifdef PUCK_FRICTION_EN
    fcnt_d   = fcnt_q;
`endif
    case (state_q)
      StWait: begin
        if (tick) begin
          state_d = StHit;
          px_d    = player_xpos_in;
          py_d    = player_ypos_in;
          pr_d    = radius_player;
        end
      end
      StHit: begin
        state_d = StWall;
        if (hit) begin
          vx_d = sat(hit_vel(neg_x));
          vy_d = zero_y ? Zero : sat(hit_vel(neg_y));
        end
      end
      StWall: begin
        state_d = StMove;
        if (((ys - RadS) <= Zero && vy_q < Zero) || ((ys + RadS) >= YEdge && vy_q > Zero))
          vy_d = sat(-vy_q);
        if (!band_cur &&
            (((xs - RadS) <= Zero && vx_q < Zero) || ((xs + RadS) >= XEdge && vx_q > Zero)))
          vx_d = sat(-vx_q);
      end
      StMove: begin
        state_d = StWait;
        x_d     = nx_c;
        y_d     = ny_c;
`ifdef PUCK_FRICTION_EN
        if (fcnt_q == FcntW'(FRICTION_PERIOD - 1)) begin
          fcnt_d = '0;
          vx_d = (vx_q > Zero) ? vx_q - 13'sd1 : (vx_q < Zero) ? vx_q + 13'sd1 : Zero;
          vy_d = (vy_q > Zero) ? vy_q - 13'sd1 : (vy_q < Zero) ? vy_q + 13'sd1 : Zero;
        end else begin
          fcnt_d = fcnt_q + FcntW'(1);
        end
`endif
        if (band_new && nx <= Zero) begin
          goal_r_d = 1'b1;
          x_d = XMid;
          y_d = YMid;
          vx_d = Zero;
          vy_d = Zero;
        end else if (band_new && nx >= XEdge) begin
          goal_l_d = 1'b1;
          x_d = XMid;
          y_d = YMid;
          vx_d = Zero;
          vy_d = Zero;
        end
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= StWait;
      vsync_q  <= 1'b0;
      x_q      <= XMid;
      y_q      <= YMid;
      vx_q     <= Zero;
      vy_q     <= Zero;
      px_q     <= '0;
      py_q     <= '0;
      pr_q     <= '0;
      goal_l_q <= 1'b0;
      goal_r_q <= 1'b0;
`ifdef PUCK_FRICTION_EN
      fcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vsync_q  <= vsync_in;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      px_q     <= px_d;
      py_q     <= py_d;
      pr_q     <= pr_d;
      goal_l_q <= goal_l_d;
      goal_r_q <= goal_r_d;
`ifdef PUCK_FRICTION_EN
      fcnt_q   <= fcnt_d;
`endif
    end
  end

  assign xpos_out    = x_q;
  assign ypos_out    = y_q;
  assign radius_puck = 8'(RADIUS);
  assign goal_left   = goal_l_q;
  assign goal_right  = goal_r_q;
  assign busy        = (state_q != StWait);

endmodule

// File: tb/tb_puck_ctl.sv
// Directed bench for puck_ctl: table of frame runs with hand-computed trajectories plus
// hand-written reset, dropped-tick and friction sequences.
module tb_puck_ctl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        vsync_in;
  logic [11:0] player_xpos_in, player_ypos_in;
  logic [7:0]  radius_player;
  logic [11:0] xpos_out, ypos_out;
  logic [7:0]  radius_puck;
  logic        goal_left, goal_right, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int gl_cnt = 0;
  int gr_cnt = 0;
  int both_cnt = 0;

  puck_ctl dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .vsync_in      (vsync_in),
    .player_xpos_in(player_xpos_in),
    .player_ypos_in(player_ypos_in),
    .radius_player (radius_player),
    .xpos_out      (xpos_out),
    .ypos_out      (ypos_out),
    .radius_puck   (radius_puck),
    .goal_left     (goal_left),
    .goal_right    (goal_right),
    .busy          (busy)
  );

  always #5 clk_in = ~clk_in;

  // Counts high cycles, so a pulse wider than one cycle shows up as an extra goal.
  always @(posedge clk_in) begin
    #1;
    if (goal_left) gl_cnt++;
    if (goal_right) gr_cnt++;
    if (goal_left && goal_right) both_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_player(input int px, input int py, input int pr);
    player_xpos_in = 12'(px);
    player_ypos_in = 12'(py);
    radius_player  = 8'(pr);
  endtask

  task automatic frame();
    int n;
    @(negedge clk_in);
    vsync_in = 1'b1;
    @(negedge clk_in);
    vsync_in = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      n++;
      @(negedge clk_in);
    end
    check("busy_cycles", n, 3);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
  endtask

  typedef struct {
    int px, py, pr;
    int ticks;
    int ex, ey;
    int egl, egr;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int gl0, gr0;
    rst = 1'b1;
    vsync_in = 1'b0;
    set_player(0, 0, 0);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    check("reset_x", int'(xpos_out), 512);
    check("reset_y", int'(ypos_out), 384);
    check("reset_radius", int'(radius_puck), 10);
    check("reset_busy", int'(busy), 0);
    check("reset_goals", int'(goal_left) + int'(goal_right), 0);

    // Player is applied on the first tick of a row only; later ticks use a far player.
    tbl[0]  = '{500, 384, 20, 1,  518, 384, 0, 0};
    tbl[1]  = '{0,   0,   0,  3,  536, 384, 0, 0};
    tbl[2]  = '{300, 300, 20, 80, 1016, 384, 0, 0};
    tbl[3]  = '{0,   0,   0,  1,  1022, 384, 0, 0};
    tbl[4]  = '{0,   0,   0,  1,  512, 384, 1, 0};
    tbl[5]  = '{0,   0,   0,  1,  512, 384, 0, 0};
    tbl[6]  = '{524, 384, 20, 1,  506, 384, 0, 0};
    tbl[7]  = '{0,   0,   0,  83, 8,   384, 0, 0};
    tbl[8]  = '{0,   0,   0,  1,  2,   384, 0, 0};
    tbl[9]  = '{0,   0,   0,  1,  512, 384, 0, 1};
    tbl[10] = '{0,   0,   0,  1,  512, 384, 0, 0};
    tbl[11] = '{500, 396, 20, 1,  518, 378, 0, 0};
    tbl[12] = '{0,   0,   0,  61, 884, 12,  0, 0};
    tbl[13] = '{0,   0,   0,  1,  890, 10,  0, 0};
    tbl[14] = '{0,   0,   0,  1,  896, 16,  0, 0};
    tbl[15] = '{0,   0,   0,  19, 1010, 130, 0, 0};
    tbl[16] = '{0,   0,   0,  1,  1013, 136, 0, 0};
    tbl[17] = '{0,   0,   0,  1,  1007, 142, 0, 0};
    tbl[18] = '{0,   0,   0,  1,  1001, 148, 0, 0};

`ifndef PUCK_FRICTION_EN
    for (int i = 0; i < 19; i++) begin
      gl0 = gl_cnt;
      gr0 = gr_cnt;
      set_player(tbl[i].px, tbl[i].py, tbl[i].pr);
      frame();
      set_player(0, 0, 0);
      for (int t = 1; t < tbl[i].ticks; t++) frame();
      check($sformatf("row%0d_x", i), int'(xpos_out), tbl[i].ex);
      check($sformatf("row%0d_y", i), int'(ypos_out), tbl[i].ey);
      check($sformatf("row%0d_goal_left", i), gl_cnt - gl0, tbl[i].egl);
      check($sformatf("row%0d_goal_right", i), gr_cnt - gr0, tbl[i].egr);
    end
`endif

    // Reset held for two cycles while the FSM sits in MOVE.
    set_player(0, 0, 0);
    @(negedge clk_in);
    vsync_in = 1'b1;
    @(negedge clk_in);
    vsync_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    check("midmove_reset_x", int'(xpos_out), 512);
    check("midmove_reset_y", int'(ypos_out), 384);
    check("midmove_reset_busy", int'(busy), 0);
    check("midmove_reset_goals", int'(goal_left) + int'(goal_right), 0);
    frame();
    check("post_reset_still_x", int'(xpos_out), 512);
    check("post_reset_still_y", int'(ypos_out), 384);

    // Second rising edge of vsync while busy must be ignored.
    set_player(500, 384, 20);
    @(negedge clk_in);
    vsync_in = 1'b1;
    @(negedge clk_in);
    vsync_in = 1'b0;
    @(negedge clk_in);
    vsync_in = 1'b1;
    @(negedge clk_in);
    vsync_in = 1'b0;
    @(negedge clk_in);
    check("dropped_tick_busy", int'(busy), 0);
    check("dropped_tick_x", int'(xpos_out), 518);
    set_player(0, 0, 0);
    frame();
    check("after_drop_x", int'(xpos_out), 524);

    // Friction: 17 ticks at vx=+6 starting from centre.
    do_reset();
    set_player(500, 384, 20);
    frame();
    set_player(0, 0, 0);
    for (int t = 1; t < 17; t++) frame();
`ifdef PUCK_FRICTION_EN
    check("friction_x", int'(xpos_out), 604);
`else
    check("friction_x", int'(xpos_out), 614);
`endif
    check("friction_y", int'(ypos_out), 384);

    check("goals_never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
